// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rippleCarryAdder_4bit.sv
// Existing 4-bit ripple-carry adder built from a chain of full adders.
module rippleCarryAdder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial a+b+cin using one shared 4-bit adder, with valid/ready handshakes.
// Optional signed-overflow output ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NUM_NIB = nibble_count(WIDTH);
  localparam int unsigned CNT_W   = cnt_width(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  state_t               state;
  state_t               state_next;
  logic                 in_ready_d;
  logic                 out_valid_d;

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     sum_q;
  logic [WIDTH-1:0]     sum_d;
  logic                 carry_q;
  logic                 cout_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [NIBBLE_W-1:0]  nib_a;
  logic [NIBBLE_W-1:0]  nib_b;
  logic [NIBBLE_W-1:0]  nib_sum;
  logic                 nib_cout;

  logic                 accept;
  logic                 last_nib;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign last_nib = (cnt_q == LAST_NIB);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept)    state_next = ST_ADD;
      ST_ADD:  if (last_nib)  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs for the coming state, registered below.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_next)
      ST_IDLE: in_ready_d  = 1'b1;
      ST_DONE: out_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NUM_NIB; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  rippleCarryAdder_4bit u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Replace only the addressed nibble; the rest keeps the previous result.
  always_comb begin
    sum_d = sum_q;
    for (int unsigned i = 0; i < NUM_NIB; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
      end
    end
  end

  // Operand latch, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state == ST_ADD) begin
      sum_q   <= sum_d;
      carry_q <= nib_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_nib) begin
        cout_q <= nib_cout;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Same-sign operands whose result sign differs; decided on the top nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state == ST_ADD) && last_nib) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=16 and WIDTH=32.
module tb_serial_add_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, cout32;
  logic [31:0] a32, b32, sum32;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf16, ovf32;
`endif

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf16)
`endif
  );

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf32)
`endif
  );

  exp_t q16[$];
  exp_t q32[$];
  int   rdy_mode = 0;
  int   last_acc16 = 0;
  int   last_acc32 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer addition, signed overflow from the signed value range.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv);
    exp_t        e;
    longint      mask, am, bm, s, sa, sb, r, half;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    am   = longint'({32'd0, av}) & mask;
    bm   = longint'({32'd0, bv}) & mask;
    s    = am + bm + longint'(cv);
    e.sum  = 32'(s & mask);
    e.cout = s[w];
    sa   = (am >= half) ? am - (mask + 1) : am;
    sb   = (bm >= half) ? bm - (mask + 1) : bm;
    r    = sa + sb + longint'(cv);
    e.ovf  = (r > half - 1) || (r < -half);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready16 : in_ready32;
  endfunction

  // Offer one operand set and return just after the accepting edge.
  task automatic send(input int sel, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input bit chk_tp);
    exp_t e;
    int   n = 0;
    if (sel == 0) begin
      a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv; in_valid16 = 1'b1;
    end else begin
      a32 = av; b32 = bv; cin32 = cv; in_valid32 = 1'b1;
    end
    while (!rdy(sel) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(n), 64'(0));
      in_valid16 = 1'b0; in_valid32 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e     = model((sel == 0) ? 16 : 32, av, bv, cv);
    e.acc = cyc;
    if (sel == 0) begin
      if (chk_tp) chk("throughput16", 64'(cyc - last_acc16), 64'(6));
      last_acc16 = cyc;
      q16.push_back(e);
      in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end else begin
      if (chk_tp) chk("throughput32", 64'(cyc - last_acc32), 64'(10));
      last_acc32 = cyc;
      q32.push_back(e);
      in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
    end
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (((sel == 0) ? (q16.size() != 0 || !in_ready16) : (q32.size() != 0 || !in_ready32))
           && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) chk("drain_timeout", 64'(n), 64'(0));
  endtask

  // Consumer-side ready for the 16-bit instance.
  initial begin
    out_ready16 = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rdy_mode == 0)      out_ready16 = 1'b1;
      else if (rdy_mode == 1) out_ready16 = ($urandom_range(0, 2) != 0);
      else                    out_ready16 = 1'b0;
    end
  end

  // Monitor 16: latency on first presentation, value every valid cycle, pop on handshake.
  logic pv16 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid16) begin
        if (q16.size() == 0) begin
          chk("spurious_valid16", 64'(out_valid16), 64'(0));
        end else begin
          if (!pv16) chk("latency16", 64'(cyc - q16[0].acc), 64'(4));
          chk("sum16", 64'(sum16), 64'(q16[0].sum));
          chk("cout16", 64'(cout16), 64'(q16[0].cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf16", 64'(ovf16), 64'(q16[0].ovf));
`endif
          if (out_ready16) void'(q16.pop_front());
        end
      end
      pv16 = out_valid16 && !out_ready16;
    end else begin
      pv16 = 1'b0;
    end
  end

  logic pv32 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid32) begin
        if (q32.size() == 0) begin
          chk("spurious_valid32", 64'(out_valid32), 64'(0));
        end else begin
          if (!pv32) chk("latency32", 64'(cyc - q32[0].acc), 64'(8));
          chk("sum32", 64'(sum32), 64'(q32[0].sum));
          chk("cout32", 64'(cout32), 64'(q32[0].cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf32", 64'(ovf32), 64'(q32[0].ovf));
`endif
          if (out_ready32) void'(q32.pop_front());
        end
      end
      pv32 = out_valid32 && !out_ready32;
    end else begin
      pv32 = 1'b0;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; out_ready32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready16", 64'(in_ready16), 64'(1));
    chk("rst_out_valid16", 64'(out_valid16), 64'(0));
    chk("rst_sum16", 64'(sum16), 64'(0));
    chk("rst_cout16", 64'(cout16), 64'(0));
    chk("rst_in_ready32", 64'(in_ready32), 64'(1));
    chk("rst_sum32", 64'(sum32), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf16", 64'(ovf16), 64'(0));
`endif
    rst_n = 1'b1;

    // Directed vectors, back-to-back with the consumer always ready.
    send(0, 32'h1234, 32'h4321, 1'b0, 1'b0);
    send(0, 32'hFFFF, 32'h0000, 1'b1, 1'b1);
    send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b1);
    send(0, 32'h8000, 32'h8000, 1'b0, 1'b1);
    wait_idle(0);

    // Backpressure: result must hold while new operands are waved at the input.
    rdy_mode = 2;
    send(0, 32'h0F0F, 32'h0101, 1'b1, 1'b0);
    n = 0;
    while (!out_valid16 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) chk("bp_valid_timeout", 64'(n), 64'(0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid16 = k[0]; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      chk("bp_in_ready16", 64'(in_ready16), 64'(0));
      chk("bp_out_valid16", 64'(out_valid16), 64'(1));
    end
    in_valid16 = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    chk("bp_release_in_ready16", 64'(in_ready16), 64'(1));
    chk("bp_release_out_valid16", 64'(out_valid16), 64'(0));
    wait_idle(0);

    // Reset on the second ADD edge aborts without a result.
    send(0, 32'hAAAA, 32'h5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q16.delete();
    chk("abort_in_ready16", 64'(in_ready16), 64'(1));
    chk("abort_sum16", 64'(sum16), 64'(0));
    chk("abort_out_valid16", 64'(out_valid16), 64'(0));
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(0, 32'h0001, 32'h0001, 1'b0, 1'b0);
    wait_idle(0);

    // Random operands with a randomly stalling consumer.
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) send(0, $urandom, $urandom, 1'($urandom), 1'b0);
    wait_idle(0);
    rdy_mode = 0;

    // 32-bit instance.
    send(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) send(1, $urandom, $urandom, 1'($urandom), 1'b0);
    wait_idle(1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block idle and able to accept operands.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in to nibble 0.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: sum  output  WIDTH  result a+b+cin, modulo 2^WIDTH.
REQ-012 Port: cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL compute a+b+cin serially, one 4-bit nibble per cycle, through a single shared 4-bit ripple-carry adder.
REQ-014 FSM states SHALL be IDLE, ADD and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE -> ADD on an edge where in_valid && in_ready; that edge latches a, b and cin, clears the nibble counter and loads the carry register with cin.
REQ-017 Each ADD edge SHALL write adder sum to sum[4i+3:4i] (i = counter), load the carry register with adder cout, and increment the counter.
REQ-018 ADD -> DONE on the edge processing nibble WIDTH/4-1; out_valid SHALL rise exactly WIDTH/4 edges after the accepting edge.
REQ-019 cout SHALL equal the carry register after the last nibble; sum and cout SHALL hold stable throughout DONE.
REQ-020 DONE -> IDLE on an edge with out_ready=1; with out_ready=0, DONE SHALL hold indefinitely (backpressure).
REQ-021 Changes on in_valid, a, b or cin outside IDLE SHALL have no effect on the operation in flight.
REQ-022 Throughput SHALL be one operation per WIDTH/4+2 cycles under continuous handshakes (one IDLE bubble).
REQ-023 sum SHALL retain the last completed result in IDLE until overwritten nibble-by-nibble in the next ADD.

Reset
REQ-024 With rst_n=0 at a rising edge: state=IDLE, counter=0, carry=0, sum=0, cout=0, out_valid=0; in_ready=1 from the first cycle after reset.
REQ-025 Reset asserted in ADD or DONE SHALL abort the operation with no result produced.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN, when defined, SHALL add output port ovf (1 bit): signed two's-complement overflow, (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), valid and stable in DONE, 0 at reset.
REQ-027 Without SERIAL_ADD_OVF_EN, the port ovf and all associated logic SHALL be absent.

Structure
REQ-028 Package serial_add_pkg SHALL hold the FSM state enum typedef and constant NIBBLE_W=4.
REQ-029 The block SHALL instantiate the team's existing rippleCarryAdder_4bit (ports a, b, cin, sum, cout) as its single sub-module; no other adder logic is permitted.

Verification
REQ-030 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid 4 edges after accept.
REQ-031 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles).
REQ-032 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1 (SERIAL_ADD_OVF_EN defined); a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-033 out_ready=0 for 10 cycles in DONE -> out_valid, sum, cout held; in_valid pulses with new operands ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst_n=0 on the 2nd ADD edge of a=0xAAAA, b=0x5555 -> IDLE, sum=0, out_valid never asserted; next operation a=0x0001, b=0x0001 -> sum=0x0002.
REQ-035 WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid 8 edges after accept.
